// File: rtl/dose_interval_timer.sv
// Dose interval timer: counts prescaler ticks into minutes, down-counts a dose interval,
// holds a reminder alarm until ack or timeout. Optional snooze: SNOOZE_DOSE_TIMER_EN.
module dose_interval_timer #(
  parameter int unsigned TICKS_PER_MIN     = 60,
  parameter int unsigned ALARM_TIMEOUT_MIN = 15,
  parameter int unsigned SNOOZE_MIN        = 5,
  parameter int unsigned MISS_W            = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              tick,
  input  logic              start,
  input  logic              stop,
  input  logic [7:0]        interval_min,
  input  logic              ack,
  input  logic              snooze,
  output logic              alarm,
  output logic              busy,
  output logic [7:0]        remaining_min,
  output logic [MISS_W-1:0] missed_count
);

  localparam int unsigned TickW = (TICKS_PER_MIN > 2) ? $clog2(TICKS_PER_MIN) : 1;
  localparam int unsigned ToW   = $clog2(ALARM_TIMEOUT_MIN + 1);

  localparam logic [TickW-1:0] TickLast     = TickW'(TICKS_PER_MIN - 1);
  localparam logic [ToW-1:0]   ToLast       = ToW'(ALARM_TIMEOUT_MIN - 1);
  localparam logic [7:0]       SnoozeReload = 8'(SNOOZE_MIN);

  typedef enum logic [1:0] {StIdle, StRun, StAlarm} state_e;

  state_e             state_q, state_d;
  logic [TickW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [ToW-1:0]     to_cnt_q, to_cnt_d;
  logic [7:0]         rem_q, rem_d;
  logic [7:0]         interval_q, interval_d;
  logic [MISS_W-1:0]  missed_q, missed_d;
  logic               alarm_q, alarm_d;
  logic               busy_q, busy_d;
  logic               active;
  logic               min_strobe;
  logic               snooze_hit;

`ifdef SNOOZE_DOSE_TIMER_EN
  assign snooze_hit = snooze;
`else
  logic unused_snooze;
  assign unused_snooze = snooze ^ SnoozeReload[0];
  assign snooze_hit    = 1'b0;
`endif

  assign active     = (state_q != StIdle);
  assign min_strobe = active && tick && (tick_cnt_q == TickLast);

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    to_cnt_d   = to_cnt_q;
    rem_d      = rem_q;
    interval_d = interval_q;
    missed_d   = missed_q;
    alarm_d    = alarm_q;

    if (active && tick) begin
      tick_cnt_d = min_strobe ? '0 : tick_cnt_q + 1'b1;
    end

    if (stop) begin
      state_d = StIdle;
      alarm_d = 1'b0;
      rem_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start && (interval_min != 8'd0)) begin
            interval_d = interval_min;
            rem_d      = interval_min;
            missed_d   = '0;
            state_d    = StRun;
          end
        end
        StRun: begin
          if (min_strobe) begin
            if (rem_q == 8'd1) begin
              state_d  = StAlarm;
              rem_d    = '0;
              alarm_d  = 1'b1;
              to_cnt_d = '0;
            end else begin
              rem_d = rem_q - 8'd1;
            end
          end
        end
        StAlarm: begin
          if (ack) begin
            alarm_d = 1'b0;
            rem_d   = interval_q;
            state_d = StRun;
          end else if (snooze_hit) begin
            alarm_d = 1'b0;
            rem_d   = SnoozeReload;
            state_d = StRun;
          end else if (min_strobe) begin
            if (to_cnt_q == ToLast) begin
              if (missed_q != '1) missed_d = missed_q + 1'b1;
              alarm_d = 1'b0;
              rem_d   = interval_q;
              state_d = StRun;
            end else begin
              to_cnt_d = to_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = StIdle;
          alarm_d = 1'b0;
          rem_d   = '0;
        end
      endcase
    end

    // Minute phase restarts on every state change.
    if (state_d != state_q) tick_cnt_d = '0;
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      tick_cnt_q <= '0;
      to_cnt_q   <= '0;
      rem_q      <= '0;
      interval_q <= '0;
      missed_q   <= '0;
      alarm_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      to_cnt_q   <= to_cnt_d;
      rem_q      <= rem_d;
      interval_q <= interval_d;
      missed_q   <= missed_d;
      alarm_q    <= alarm_d;
      busy_q     <= busy_d;
    end
  end

  assign alarm         = alarm_q;
  assign busy          = busy_q;
  assign remaining_min = rem_q;
  assign missed_count  = missed_q;

endmodule

// File: tb/tb_dose_interval_timer.sv
// Directed scoreboard bench for dose_interval_timer (TICKS_PER_MIN=4, timeout 2, snooze 1).
module tb_dose_interval_timer;

  logic       clock;
  logic       reset;
  logic       tick;
  logic       start;
  logic       stop;
  logic [7:0] interval_min;
  logic       ack;
  logic       snooze;
  logic       alarm;
  logic       busy;
  logic [7:0] remaining_min;
  logic [3:0] missed_count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      tag;
    logic       alarm;
    logic       busy;
    logic [7:0] rem;
    logic [3:0] missed;
  } exp_t;

  exp_t sb[$];

  dose_interval_timer #(
    .TICKS_PER_MIN    (4),
    .ALARM_TIMEOUT_MIN(2),
    .SNOOZE_MIN       (1),
    .MISS_W           (4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .tick         (tick),
    .start        (start),
    .stop         (stop),
    .interval_min (interval_min),
    .ack          (ack),
    .snooze       (snooze),
    .alarm        (alarm),
    .busy         (busy),
    .remaining_min(remaining_min),
    .missed_count (missed_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cmp(input string tag, input string field, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s.%s: observed %0h expected %0h", tag, field, obs, exp);
    end
  endtask

  task automatic expect_push(input string tag, input logic a, input logic b,
                             input logic [7:0] r, input logic [3:0] m);
    exp_t e;
    e.tag = tag; e.alarm = a; e.busy = b; e.rem = r; e.missed = m;
    sb.push_back(e);
  endtask

  task automatic check_sb();
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      cmp(e.tag, "alarm", {7'd0, alarm}, {7'd0, e.alarm});
      cmp(e.tag, "busy", {7'd0, busy}, {7'd0, e.busy});
      cmp(e.tag, "remaining_min", remaining_min, e.rem);
      cmp(e.tag, "missed_count", {4'd0, missed_count}, {4'd0, e.missed});
    end
  endtask

  // Inputs are applied just after an edge and held for exactly one clock.
  task automatic drive(input logic t, input logic s, input logic p, input logic [7:0] iv,
                       input logic a, input logic z);
    tick = t; start = s; stop = p; interval_min = iv; ack = a; snooze = z;
    @(posedge clock);
    #1;
    tick = 1'b0; start = 1'b0; stop = 1'b0; ack = 1'b0; snooze = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b0; tick = 1'b0; start = 1'b0; stop = 1'b0;
    interval_min = 8'd0; ack = 1'b0; snooze = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    expect_push("reset", 1'b0, 1'b0, 8'd0, 4'd0);
    check_sb();
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Interval countdown
    expect_push("start3", 1'b0, 1'b1, 8'd3, 4'd0);
    drive(1'b0, 1'b1, 1'b0, 8'd3, 1'b0, 1'b0);
    check_sb();
    expect_push("tick3", 1'b0, 1'b1, 8'd3, 4'd0);
    ticks(3);
    check_sb();
    expect_push("tick4", 1'b0, 1'b1, 8'd2, 4'd0);
    ticks(1);
    check_sb();
    expect_push("tick8", 1'b0, 1'b1, 8'd1, 4'd0);
    ticks(4);
    check_sb();
    expect_push("tick12", 1'b1, 1'b1, 8'd0, 4'd0);
    ticks(4);
    check_sb();

    // Ack in ALARM, then ack in RUN
    expect_push("ack_alarm", 1'b0, 1'b1, 8'd3, 4'd0);
    drive(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    check_sb();
    expect_push("ack_run", 1'b0, 1'b1, 8'd3, 4'd0);
    drive(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    check_sb();

    // Timeout counts a miss
    expect_push("alarm2", 1'b1, 1'b1, 8'd0, 4'd0);
    ticks(12);
    check_sb();
    expect_push("pre_timeout", 1'b1, 1'b1, 8'd0, 4'd0);
    ticks(7);
    check_sb();
    expect_push("timeout", 1'b0, 1'b1, 8'd3, 4'd1);
    ticks(1);
    check_sb();

    // Ack coinciding with timeout wins
    expect_push("alarm3", 1'b1, 1'b1, 8'd0, 4'd1);
    ticks(12);
    ticks(7);
    check_sb();
    expect_push("ack_timeout", 1'b0, 1'b1, 8'd3, 4'd1);
    drive(1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    check_sb();

    // Start ignored in RUN, stop holds missed_count
    expect_push("run_rem2", 1'b0, 1'b1, 8'd2, 4'd1);
    ticks(4);
    check_sb();
    expect_push("start_in_run", 1'b0, 1'b1, 8'd2, 4'd1);
    drive(1'b0, 1'b1, 1'b0, 8'd7, 1'b0, 1'b0);
    check_sb();
    expect_push("stop", 1'b0, 1'b0, 8'd0, 4'd1);
    drive(1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0);
    check_sb();
    expect_push("start_zero", 1'b0, 1'b0, 8'd0, 4'd1);
    drive(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
    check_sb();
    expect_push("idle_ticks", 1'b0, 1'b0, 8'd0, 4'd1);
    ticks(5);
    check_sb();

    // Snooze behaviour
    expect_push("start1", 1'b0, 1'b1, 8'd1, 4'd0);
    drive(1'b0, 1'b1, 1'b0, 8'd1, 1'b0, 1'b0);
    check_sb();
    expect_push("alarm_s", 1'b1, 1'b1, 8'd0, 4'd0);
    ticks(4);
    check_sb();
`ifdef SNOOZE_DOSE_TIMER_EN
    expect_push("snooze", 1'b0, 1'b1, 8'd1, 4'd0);
    drive(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
    check_sb();
    expect_push("snooze_realarm", 1'b1, 1'b1, 8'd0, 4'd0);
    ticks(4);
    check_sb();
    expect_push("snooze_timeout", 1'b0, 1'b1, 8'd1, 4'd1);
    ticks(8);
    check_sb();
`else
    expect_push("snooze_ignored", 1'b1, 1'b1, 8'd0, 4'd0);
    drive(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
    check_sb();
    expect_push("snooze_hold", 1'b1, 1'b1, 8'd0, 4'd0);
    ticks(4);
    check_sb();
    expect_push("snooze_timeout", 1'b0, 1'b1, 8'd1, 4'd1);
    ticks(4);
    check_sb();
`endif

    // Asynchronous reset mid-run, checked before the next edge
    ticks(2);
    #2;
    reset = 1'b0;
    #1;
    expect_push("async_reset", 1'b0, 1'b0, 8'd0, 4'd0);
    check_sb();
    #2;
    reset = 1'b1;
    @(posedge clock);
    #1;
    expect_push("post_reset", 1'b0, 1'b0, 8'd0, 4'd0);
    ticks(2);
    check_sb();

    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d entries expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
